subckt_toggle_profiler: RTL and testbench
=========================================

SUBCKT_TOGGLE_PROFILER -- requirements
Module: subckt_toggle_profiler

Interface
REQ-001 SHALL have parameter NUM_VEC, default 16: vectors applied per run (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 16: width of all counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle run request, honoured only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = exhaustive count, 1 = LFSR; sampled with start.
REQ-007 SHALL have port vec_out  output  4  stimulus to sub-circuit; bits 0..3 drive n_1..n_4.
REQ-008 SHALL have port resp_in  input  1  sub-circuit response (n_8), combinational from vec_out.
REQ-009 SHALL have port busy  output  1  high in DRIVE and SAMPLE.
REQ-010 SHALL have port done  output  1  high in DONE, held until the next start or rst.
REQ-011 SHALL have ports toggle_cnt, ones_cnt, vec_cnt  output  CNT_W each: response transitions, response-high samples, vectors applied.
REQ-012 SHALL have port sig  output  16  response signature (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-014 IDLE + start SHALL clear all counters and sig, load vec_out = 0 (mode 0) or 4'b0001 (mode 1), and enter DRIVE.
REQ-015 DRIVE SHALL hold vec_out for one cycle, then enter SAMPLE.
REQ-016 SAMPLE SHALL register resp_in, increment vec_cnt and increment ones_cnt when resp_in = 1.
REQ-017 SAMPLE SHALL increment toggle_cnt when resp_in differs from the previous sample; the first sample of a run SHALL never count as a toggle.
REQ-018 SAMPLE SHALL advance vec_out: mode 0 adds 1 modulo 16 (15 wraps to 0); mode 1 steps the x^4+x^3+1 Fibonacci LFSR, period 15, never reaching 0.
REQ-019 SAMPLE SHALL enter DONE when vec_cnt reaches NUM_VEC; otherwise it SHALL enter DRIVE.
REQ-020 All counters SHALL saturate at all-ones and never wrap.
REQ-021 DONE + start SHALL restart exactly as in REQ-014; otherwise the FSM SHALL stay in DONE with results held.
REQ-022 start SHALL be ignored in DRIVE and SAMPLE.
REQ-023 Each vector SHALL take 2 cycles, so a run SHALL take 2*NUM_VEC cycles from start to done.

Reset
REQ-024 rst SHALL force IDLE, with vec_out = 0, busy = 0, done = 0, all counters = 0 and sig = 0, on the next edge from any state, including mid-run.
REQ-025 rst SHALL take priority over start in the same cycle.

Configuration
REQ-026 With PROFILER_MISR_EN defined, sig SHALL be a 16-bit MISR (polynomial x^16+x^12+x^3+x+1) shifting in resp_in on each SAMPLE.
REQ-027 Without PROFILER_MISR_EN, sig SHALL be constant 0 and no MISR flops SHALL exist.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the LFSR seed and taps, and the MISR polynomial constant.
REQ-029 The pattern source (counter/LFSR) SHALL be one sub-module, subckt_pattern_gen; the counters and FSM SHALL stay in the top.

Verification
REQ-030 mode 0, NUM_VEC 16, resp_in = (v1&v2) ^ (~v3 & (v0 ^ (v1&v2))) -> done after 32 cycles; toggle_cnt 9, ones_cnt 6, vec_cnt 16.
REQ-031 mode 0, NUM_VEC 16, resp_in tied 0 -> toggle_cnt 0, ones_cnt 0, sig 0.
REQ-032 mode 0, NUM_VEC 16, resp_in = vec_out[0] -> toggle_cnt 15, ones_cnt 8.
REQ-033 mode 1, NUM_VEC 15 -> vec_out visits all 15 non-zero values exactly once; vec_cnt 15.
REQ-034 rst asserted during the 5th SAMPLE -> next cycle busy 0, done 0, all outputs 0; a start pulse during busy -> no effect on counts.
REQ-035 With PROFILER_MISR_EN, the REQ-030 run -> sig equals the package-constant MISR model value; without it -> sig 0.

Source files
------------

// File: rtl/subckt_toggle_profiler_pkg.sv
// Shared types and constants for the sub-circuit toggle profiler.
// Holds the FSM state enum, the LFSR seed/taps and the MISR polynomial.
package subckt_toggle_profiler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned SIG_W  = 16;

  // Left-shifting Fibonacci LFSR; feedback is the XOR of the tapped bits.
  localparam logic [VEC_W-1:0] LFSR_SEED = 4'b0001;
  localparam logic [VEC_W-1:0] LFSR_TAPS = 4'b1001;

  // x^16 + x^12 + x^3 + x + 1 (x^16 implied).
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h100B;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic d);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : '0) ^ {{(SIG_W-1){1'b0}}, d};
  endfunction

endpackage

// File: rtl/subckt_pattern_gen.sv
// Stimulus source for the profiler: 4-bit up-counter (mode 0) or
// period-15 LFSR (mode 1); mode is latched on load.
module subckt_pattern_gen
  import subckt_toggle_profiler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  output logic [VEC_W-1:0] vec
);

  logic mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      vec    <= '0;
    end else if (load) begin
      mode_q <= mode;
      vec    <= mode ? LFSR_SEED : '0;
    end else if (step) begin
      if (mode_q) vec <= {vec[VEC_W-2:0], ^(vec & LFSR_TAPS)};
      else        vec <= vec + VEC_W'(1);
    end
  end

endmodule

// File: rtl/subckt_toggle_profiler.sv
// Applies NUM_VEC vectors to a 4-input sub-circuit and profiles its response.
// Optional response signature MISR enabled by PROFILER_MISR_EN.
module subckt_toggle_profiler
  import subckt_toggle_profiler_pkg::*;
#(
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic [VEC_W-1:0] vec_out,
  input  logic             resp_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [SIG_W-1:0] sig
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             prev_resp;
  logic             load_c;
  logic             step_c;
  logic             last_c;
  logic [CNT_W-1:0] vec_cnt_inc_c;

  assign load_c        = start && (state == ST_IDLE || state == ST_DONE);
  assign step_c        = (state == ST_SAMPLE);
  assign vec_cnt_inc_c = (vec_cnt == CNT_MAX) ? vec_cnt : vec_cnt + CNT_W'(1);
  // A saturated vec_cnt also ends the run so a too-narrow counter cannot hang.
  assign last_c        = (32'(vec_cnt_inc_c) >= 32'(NUM_VEC)) || (vec_cnt_inc_c == CNT_MAX);

  subckt_pattern_gen u_pattern_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load_c),
    .mode (mode),
    .step (step_c),
    .vec  (vec_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      prev_resp  <= 1'b0;
      toggle_cnt <= '0;
      ones_cnt   <= '0;
      vec_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_DRIVE;
            busy       <= 1'b1;
            done       <= 1'b0;
            prev_resp  <= 1'b0;
            toggle_cnt <= '0;
            ones_cnt   <= '0;
            vec_cnt    <= '0;
          end
        end
        ST_DRIVE: state <= ST_SAMPLE;
        ST_SAMPLE: begin
          prev_resp <= resp_in;
          vec_cnt   <= vec_cnt_inc_c;
          if (resp_in && ones_cnt != CNT_MAX)
            ones_cnt <= ones_cnt + CNT_W'(1);
          // vec_cnt == 0 marks the first sample, which has no predecessor.
          if (vec_cnt != '0 && resp_in != prev_resp && toggle_cnt != CNT_MAX)
            toggle_cnt <= toggle_cnt + CNT_W'(1);
          if (last_c) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_DRIVE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROFILER_MISR_EN
  logic [SIG_W-1:0] misr_q;

  always_ff @(posedge clk) begin
    if (rst)         misr_q <= '0;
    else if (load_c) misr_q <= '0;
    else if (step_c) misr_q <= misr_step(misr_q, resp_in);
  end

  assign sig = misr_q;
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_subckt_toggle_profiler.sv
// Scoreboard bench for subckt_toggle_profiler (NUM_VEC 16 and NUM_VEC 15 instances).
module tb_subckt_toggle_profiler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  int          pat;

  logic [3:0]  vec16, vec15;
  logic        resp16, resp15;
  logic        busy16, busy15, done16, done15;
  logic [15:0] tog16, ones16, vc16, tog15, ones15, vc15;
  logic [15:0] sig16, sig15;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          tog;
    int          ones;
    int          vc;
    logic [15:0] sig;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Expected mode-1 vector order for x^4+x^3+1 seeded with 0001.
  logic [3:0] lfsr_tab [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

  always #5 clk = ~clk;

  function automatic logic resp_f(input int p, input logic [3:0] v);
    case (p)
      0:       return (v[1] & v[2]) ^ (~v[3] & (v[0] ^ (v[1] & v[2])));
      1:       return 1'b0;
      2:       return v[0];
      default: return v[3] ^ v[1];
    endcase
  endfunction

  always_comb resp16 = resp_f(pat, vec16);
  always_comb resp15 = resp_f(pat, vec15);

  subckt_toggle_profiler #(.NUM_VEC(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_out(vec16), .resp_in(resp16),
    .busy(busy16), .done(done16), .toggle_cnt(tog16), .ones_cnt(ones16), .vec_cnt(vc16), .sig(sig16)
  );

  subckt_toggle_profiler #(.NUM_VEC(15), .CNT_W(16)) dut15 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_out(vec15), .resp_in(resp15),
    .busy(busy15), .done(done15), .toggle_cnt(tog15), .ones_cnt(ones15), .vec_cnt(vc15), .sig(sig15)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic exp_t model(input logic m, input int p, input int n);
    exp_t e;
    logic prev;
    logic r;
    logic [3:0] v;
    e.tog = 0; e.ones = 0; e.vc = n; e.sig = '0; e.cyc = 2 * n;
    prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = m ? lfsr_tab[i % 15] : 4'(i);
      r = resp_f(p, v);
      if (r) e.ones++;
      if (i > 0 && r != prev) e.tog++;
      prev = r;
      e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h100B : 16'h0000) ^ {15'b0, r};
    end
`ifndef PROFILER_MISR_EN
    e.sig = '0;
`endif
    return e;
  endfunction

  task automatic run(input logic m, input int p, input bit glitch, input string name);
    exp_t e;
    int cyc;
    int cyc15;
    int distinct;
    bit seen [16];
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    pat  = p;
    mode = m;
    sb.push_back(model(m, p, 16));
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc   = 0;
    cyc15 = -1;
    while (!done16 && cyc < 200) begin
      if (busy15) seen[vec15] = 1'b1;
      if (done15 && cyc15 < 0) cyc15 = cyc;
      if (glitch) start = (cyc == 5);
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({name, "_done"}, 32'(done16), 32'd1);
    check({name, "_cycles"}, 32'(cyc), 32'(e.cyc));
    check({name, "_busy"}, 32'(busy16), 32'd0);
    check({name, "_toggle"}, 32'(tog16), 32'(e.tog));
    check({name, "_ones"}, 32'(ones16), 32'(e.ones));
    check({name, "_vec_cnt"}, 32'(vc16), 32'(e.vc));
    check({name, "_sig"}, 32'(sig16), 32'(e.sig));
    if (m) begin
      distinct = 0;
      for (int i = 1; i < 16; i++) if (seen[i]) distinct++;
      check({name, "_n15_distinct"}, 32'(distinct), 32'd15);
      check({name, "_n15_zero_seen"}, 32'(seen[0]), 32'd0);
      check({name, "_n15_vec_cnt"}, 32'(vc15), 32'd15);
      check({name, "_n15_cycles"}, 32'(cyc15), 32'd30);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_hold"}, 32'(done16), 32'd1);
    check({name, "_vec_cnt_hold"}, 32'(vc16), 32'(e.vc));
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; mode = 1'b0; pat = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_done", 32'(done16), 32'd0);
    check("rst_vec", 32'(vec16), 32'd0);
    check("rst_cnts", 32'(tog16 | ones16 | vc16), 32'd0);
    check("rst_sig", 32'(sig16), 32'd0);
    @(negedge clk) rst = 1'b0;

    run(1'b0, 0, 1'b0, "subckt");
    run(1'b0, 1, 1'b0, "tied0");
    run(1'b0, 2, 1'b0, "v0");
    run(1'b1, 3, 1'b0, "lfsr");
    run(1'b0, 3, 1'b1, "start_busy");

    // Reset during the 5th SAMPLE cycle.
    pat = 0; mode = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 9) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("mid_vec_cnt", 32'(vc16), 32'd4);
    check("mid_busy", 32'(busy16), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy16), 32'd0);
    check("midrst_done", 32'(done16), 32'd0);
    check("midrst_vec", 32'(vec16), 32'd0);
    check("midrst_cnts", 32'(tog16 | ones16 | vc16), 32'd0);
    check("midrst_sig", 32'(sig16), 32'd0);

    // rst wins over start in the same cycle.
    @(negedge clk) begin rst = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1;
    check("rst_prio_busy", 32'(busy16), 32'd0);
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_prio_idle", 32'(busy16), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
